// File: rtl/pipeline_processor_hz.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_processor_hz
// Brief    : 5-stage IF/ID/EX/MEM/WB core with hazard unit (EX forwarding,
//            load-use stall, EX-resolved branch/jump flush). Macro FORWARD_EN
//            enables the forwarding paths; without it RAW hazards stall.
// Revision : 1.0
// ============================================================================
module pipeline_processor_hz #(
   parameter int DATA_W  = 20,
   parameter int NREG_W  = 4,
   parameter int INSTR_W = 20,
   parameter int PC_W    = 12
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [INSTR_W-1:0] InstrIn,
   output logic [PC_W-1:0]    InstrAddress,
   input  logic [DATA_W-1:0]  DataIn,
   output logic [DATA_W-1:0]  Daddress,
   output logic [DATA_W-1:0]  Dout,
   output logic               W,
   output logic               Stall,
   output logic               Flush
);
   localparam int IMM_W = INSTR_W - 4 - 2*NREG_W;
   localparam int NREG  = 2**NREG_W;

   localparam logic [3:0] c_OP_ADD    = 4'b0000;
   localparam logic [3:0] c_OP_SUB    = 4'b0001;
   localparam logic [3:0] c_OP_AND    = 4'b0010;
   localparam logic [3:0] c_OP_NOT    = 4'b0011;
   localparam logic [3:0] c_OP_OR     = 4'b0100;
   localparam logic [3:0] c_OP_ADDI   = 4'b0101;
   localparam logic [3:0] c_OP_LOAD   = 4'b1011;
   localparam logic [3:0] c_OP_STORE  = 4'b1100;
   localparam logic [3:0] c_OP_BEQ    = 4'b1101;
   localparam logic [3:0] c_OP_JMP    = 4'b1110;
   localparam logic [3:0] c_OP_BUBBLE = 4'b1111;
   localparam logic [INSTR_W-1:0] c_BUBBLE_INSTR = {c_OP_BUBBLE, {(INSTR_W-4){1'b0}}};

   function automatic logic isWriter(input logic [3:0] op);
      return op inside {c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_NOT, c_OP_ADDI, c_OP_LOAD};
   endfunction

   // True when an instruction with these fields reads register tgt.
   function automatic logic readsReg(input logic [3:0] op, input logic [NREG_W-1:0] rd,
                                     input logic [NREG_W-1:0] rs1, input logic [NREG_W-1:0] rs2,
                                     input logic [NREG_W-1:0] tgt);
      logic useRs1, useRs2, useRd;
      useRs1 = op inside {c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_NOT, c_OP_ADDI,
                          c_OP_LOAD, c_OP_STORE, c_OP_BEQ};
      useRs2 = op inside {c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR};
      useRd  = op inside {c_OP_STORE, c_OP_BEQ};
      return (useRs1 && rs1 == tgt) || (useRs2 && rs2 == tgt) || (useRd && rd == tgt);
   endfunction

   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_ifIdInstr;
   logic [PC_W-1:0]    r_ifIdPc;
   logic [3:0]         r_idExOp;
   logic [NREG_W-1:0]  r_idExRd;
   logic [DATA_W-1:0]  r_idExRs1Val, r_idExRs2Val, r_idExRdVal, r_idExImm;
   logic [PC_W-1:0]    r_idExPc;
   logic [3:0]         r_exMemOp;
   logic [NREG_W-1:0]  r_exMemRd;
   logic [DATA_W-1:0]  r_exMemRes, r_exMemStData;
   logic [3:0]         r_memWbOp;
   logic [NREG_W-1:0]  r_memWbRd;
   logic [DATA_W-1:0]  r_memWbRes;
   logic [DATA_W-1:0]  r_regs [NREG];

   logic [3:0]         w_idOp;
   logic [NREG_W-1:0]  w_idRd, w_idRs1, w_idRs2;
   logic [DATA_W-1:0]  w_idImm, w_idRs1Val, w_idRs2Val, w_idRdVal;
   logic               w_wbWe, w_hazard, w_flush;
   logic [DATA_W-1:0]  w_opA, w_opB, w_opD, w_aluRes;
   logic [PC_W-1:0]    w_target;

   // ---------------- ID: decode and write-first register read ----------------
   assign w_idOp  = r_ifIdInstr[INSTR_W-1 -: 4];
   assign w_idRd  = r_ifIdInstr[INSTR_W-5 -: NREG_W];
   assign w_idRs1 = r_ifIdInstr[INSTR_W-5-NREG_W -: NREG_W];
   assign w_idRs2 = r_ifIdInstr[IMM_W-1 -: NREG_W];
   assign w_idImm = {{(DATA_W-IMM_W){r_ifIdInstr[IMM_W-1]}}, r_ifIdInstr[IMM_W-1:0]};

   assign w_wbWe     = isWriter(r_memWbOp);
   assign w_idRs1Val = (w_wbWe && r_memWbRd == w_idRs1) ? r_memWbRes : r_regs[w_idRs1];
   assign w_idRs2Val = (w_wbWe && r_memWbRd == w_idRs2) ? r_memWbRes : r_regs[w_idRs2];
   assign w_idRdVal  = (w_wbWe && r_memWbRd == w_idRd)  ? r_memWbRes : r_regs[w_idRd];

`ifdef FORWARD_EN
   logic [NREG_W-1:0] r_idExRs1, r_idExRs2;
   logic              w_exMemFwd;

   assign w_hazard = (r_idExOp == c_OP_LOAD) &&
                     readsReg(w_idOp, w_idRd, w_idRs1, w_idRs2, r_idExRd);

   // A LOAD result is not ready in EX/MEM; the load-use stall keeps that case away.
   assign w_exMemFwd = isWriter(r_exMemOp) && (r_exMemOp != c_OP_LOAD);
   assign w_opA = (w_exMemFwd && r_exMemRd == r_idExRs1) ? r_exMemRes :
                  (w_wbWe && r_memWbRd == r_idExRs1)     ? r_memWbRes : r_idExRs1Val;
   assign w_opB = (w_exMemFwd && r_exMemRd == r_idExRs2) ? r_exMemRes :
                  (w_wbWe && r_memWbRd == r_idExRs2)     ? r_memWbRes : r_idExRs2Val;
   assign w_opD = (w_exMemFwd && r_exMemRd == r_idExRd)  ? r_exMemRes :
                  (w_wbWe && r_memWbRd == r_idExRd)      ? r_memWbRes : r_idExRdVal;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_idExRs1 <= '0;
         r_idExRs2 <= '0;
      end else begin
         r_idExRs1 <= w_idRs1;
         r_idExRs2 <= w_idRs2;
      end
   end
`else
   // MEM/WB producers are covered by the write-first register file.
   assign w_hazard = (isWriter(r_idExOp)  && readsReg(w_idOp, w_idRd, w_idRs1, w_idRs2, r_idExRd)) ||
                     (isWriter(r_exMemOp) && readsReg(w_idOp, w_idRd, w_idRs1, w_idRs2, r_exMemRd));
   assign w_opA = r_idExRs1Val;
   assign w_opB = r_idExRs2Val;
   assign w_opD = r_idExRdVal;
`endif

   // ---------------- EX: ALU and branch resolution ----------------
   always_comb begin
      w_aluRes = '0;
      case (r_idExOp)
         c_OP_ADD:                         w_aluRes = w_opA + w_opB;
         c_OP_SUB:                         w_aluRes = w_opA - w_opB;
         c_OP_AND:                         w_aluRes = w_opA & w_opB;
         c_OP_OR:                          w_aluRes = w_opA | w_opB;
         c_OP_NOT:                         w_aluRes = ~w_opA;
         c_OP_ADDI, c_OP_LOAD, c_OP_STORE: w_aluRes = w_opA + r_idExImm;
         default:                          w_aluRes = '0;
      endcase
   end

   assign w_flush  = (r_idExOp == c_OP_JMP) || (r_idExOp == c_OP_BEQ && w_opD == w_opA);
   assign w_target = r_idExPc + PC_W'(1) + r_idExImm[PC_W-1:0];

   assign Flush        = w_flush;
   assign Stall        = w_hazard && !w_flush;
   assign InstrAddress = r_pc;

   // ---------------- MEM outputs ----------------
   assign W        = (r_exMemOp == c_OP_STORE);
   assign Daddress = (r_exMemOp == c_OP_LOAD || r_exMemOp == c_OP_STORE) ? r_exMemRes : '0;
   assign Dout     = W ? r_exMemStData : '0;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_pc          <= '0;
         r_ifIdInstr   <= c_BUBBLE_INSTR;
         r_ifIdPc      <= '0;
         r_idExOp      <= c_OP_BUBBLE;
         r_idExRd      <= '0;
         r_idExRs1Val  <= '0;
         r_idExRs2Val  <= '0;
         r_idExRdVal   <= '0;
         r_idExImm     <= '0;
         r_idExPc      <= '0;
         r_exMemOp     <= c_OP_BUBBLE;
         r_exMemRd     <= '0;
         r_exMemRes    <= '0;
         r_exMemStData <= '0;
         r_memWbOp     <= c_OP_BUBBLE;
         r_memWbRd     <= '0;
         r_memWbRes    <= '0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         // Flush takes priority over the stall: the stalled instruction is on the wrong path.
         if (w_flush) begin
            r_pc        <= w_target;
            r_ifIdInstr <= c_BUBBLE_INSTR;
         end else if (!w_hazard) begin
            r_pc        <= r_pc + PC_W'(1);
            r_ifIdInstr <= InstrIn;
            r_ifIdPc    <= r_pc;
         end

         if (w_flush || w_hazard) begin
            r_idExOp     <= c_OP_BUBBLE;
            r_idExRd     <= '0;
            r_idExRs1Val <= '0;
            r_idExRs2Val <= '0;
            r_idExRdVal  <= '0;
            r_idExImm    <= '0;
         end else begin
            r_idExOp     <= w_idOp;
            r_idExRd     <= w_idRd;
            r_idExRs1Val <= w_idRs1Val;
            r_idExRs2Val <= w_idRs2Val;
            r_idExRdVal  <= w_idRdVal;
            r_idExImm    <= w_idImm;
         end
         r_idExPc <= r_ifIdPc;

         r_exMemOp     <= r_idExOp;
         r_exMemRd     <= r_idExRd;
         r_exMemRes    <= w_aluRes;
         r_exMemStData <= w_opD;

         r_memWbOp  <= r_exMemOp;
         r_memWbRd  <= r_exMemRd;
         r_memWbRes <= (r_exMemOp == c_OP_LOAD) ? DataIn : r_exMemRes;

         if (w_wbWe) r_regs[r_memWbRd] <= r_memWbRes;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pipeline_processor_hz.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_processor_hz
// Brief    : Directed and randomized bench; store traffic compared against an
//            instruction-level interpreter of the program.
// Revision : 1.0
// ============================================================================
module tb_pipeline_processor_hz;
   localparam int DATA_W = 20;
   localparam int NREG_W = 4;
   localparam int INSTR_W = 20;
   localparam int PC_W = 12;

   localparam logic [3:0] c_ADD = 4'b0000, c_SUB = 4'b0001, c_AND = 4'b0010, c_NOT = 4'b0011;
   localparam logic [3:0] c_OR = 4'b0100, c_ADDI = 4'b0101, c_LOAD = 4'b1011, c_STORE = 4'b1100;
   localparam logic [3:0] c_BEQ = 4'b1101, c_JMP = 4'b1110, c_NOPOP = 4'b0110;
   localparam logic [INSTR_W-1:0] c_NOP = 20'h60000;

`ifdef FORWARD_EN
   localparam int c_EXP_STALL_LD = 1;
   localparam int c_EXP_STALL_DEP = 0;
`else
   localparam int c_EXP_STALL_LD = 8;
   localparam int c_EXP_STALL_DEP = 4;
`endif

   logic               Clock = 1'b0;
   logic               Reset = 1'b1;
   logic [INSTR_W-1:0] InstrIn;
   logic [PC_W-1:0]    InstrAddress;
   logic [DATA_W-1:0]  DataIn, Daddress, Dout;
   logic               W, Stall, Flush;

   logic [INSTR_W-1:0] imem [0:4095];
   logic [DATA_W-1:0]  dmem [0:255];
   logic [63:0]        storeQ[$];
   logic [63:0]        expQ[$];
   int                 stallCnt, flushCnt, checks, failures;
   logic               prevFlush;
   logic [PC_W-1:0]    afterFlushPc;

   always #5 Clock = ~Clock;

   assign InstrIn = imem[InstrAddress];
   assign DataIn  = dmem[Daddress[7:0]];

   pipeline_processor_hz #(.DATA_W(DATA_W), .NREG_W(NREG_W), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
      .Clock(Clock), .Reset(Reset), .InstrIn(InstrIn), .InstrAddress(InstrAddress),
      .DataIn(DataIn), .Daddress(Daddress), .Dout(Dout), .W(W), .Stall(Stall), .Flush(Flush)
   );

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [INSTR_W-1:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                             input logic [3:0] rs1, input logic [7:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   function automatic logic [63:0] pk(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
      return {24'b0, a, d};
   endfunction

   task automatic clearImem();
      for (int i = 0; i < 4096; i++) imem[i] = c_NOP;
   endtask

   task automatic clearMon();
      storeQ.delete();
      stallCnt = 0;
      flushCnt = 0;
      prevFlush = 1'b0;
      afterFlushPc = '1;
   endtask

   task automatic doReset();
      Reset = 1'b0;
      clearMon();
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
   endtask

   // Samples at the falling edge; the bench data memory absorbs stores here.
   task automatic runCycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge Clock);
         if (W === 1'b1) begin
            storeQ.push_back(pk(Daddress, Dout));
            dmem[Daddress[7:0]] = Dout;
         end
         if (Stall === 1'b1) stallCnt++;
         if (prevFlush) afterFlushPc = InstrAddress;
         prevFlush = (Flush === 1'b1);
         if (Flush === 1'b1) flushCnt++;
      end
   endtask

   // Sequential instruction-set interpreter: one instruction at a time, no pipeline.
   task automatic runModel(input int progLen);
      logic [DATA_W-1:0] r [16];
      logic [DATA_W-1:0] m [256];
      logic [DATA_W-1:0] imm, addr;
      logic [INSTR_W-1:0] ins;
      logic [3:0] op, rd, rs1, rs2;
      logic signed [7:0] simm;
      int pc, nextPc, steps;
      for (int i = 0; i < 16; i++) r[i] = '0;
      for (int i = 0; i < 256; i++) m[i] = dmem[i];
      expQ.delete();
      pc = 0;
      steps = 0;
      while (pc < progLen && steps < 5000) begin
         ins = imem[pc];
         op = ins[19:16]; rd = ins[15:12]; rs1 = ins[11:8]; rs2 = ins[7:4];
         simm = ins[7:0];
         imm = {{12{ins[7]}}, ins[7:0]};
         addr = r[rs1] + imm;
         nextPc = pc + 1;
         case (op)
            c_ADD:   r[rd] = r[rs1] + r[rs2];
            c_SUB:   r[rd] = r[rs1] - r[rs2];
            c_AND:   r[rd] = r[rs1] & r[rs2];
            c_OR:    r[rd] = r[rs1] | r[rs2];
            c_NOT:   r[rd] = ~r[rs1];
            c_ADDI:  r[rd] = addr;
            c_LOAD:  r[rd] = m[addr[7:0]];
            c_STORE: begin
               m[addr[7:0]] = r[rd];
               expQ.push_back(pk(addr, r[rd]));
            end
            c_BEQ:   if (r[rd] == r[rs1]) nextPc = (pc + 1 + int'(simm)) & 4095;
            c_JMP:   nextPc = (pc + 1 + int'(simm)) & 4095;
            default: ;
         endcase
         pc = nextPc;
         steps++;
      end
   endtask

   function automatic logic [INSTR_W-1:0] randInstr();
      logic [3:0] op, rd, rs1, rs2;
      logic [7:0] imm;
      case ($urandom_range(0, 10))
         0: op = c_ADD;  1: op = c_SUB;   2: op = c_AND; 3: op = c_OR;
         4: op = c_NOT;  5: op = c_ADDI;  6: op = c_LOAD; 7: op = c_STORE;
         8: op = c_BEQ;  9: op = c_JMP;   default: op = c_NOPOP;
      endcase
      rd  = (op == c_STORE || op == c_BEQ) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(1, 4));
      rs1 = 4'($urandom_range(0, 4));
      rs2 = 4'($urandom_range(0, 4));
      if (op == c_BEQ || op == c_JMP) imm = 8'($urandom_range(0, 3));
      else if (op inside {c_ADD, c_SUB, c_AND, c_OR}) imm = {rs2, 4'($urandom_range(0, 15))};
      else imm = 8'($urandom_range(0, 255));
      return mk(op, rd, rs1, imm);
   endfunction

   initial begin
      bit found;
      checks = 0;
      failures = 0;
      clearImem();
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      clearMon();

      // Reset state
      #2 Reset = 1'b0;
      #1;
      checkEq("rst_pc", 64'(InstrAddress), 0);
      checkEq("rst_w", 64'(W), 0);
      checkEq("rst_daddr", 64'(Daddress), 0);
      checkEq("rst_dout", 64'(Dout), 0);
      checkEq("rst_stall", 64'(Stall), 0);
      checkEq("rst_flush", 64'(Flush), 0);

      // Forwarded ALU chain, then load-use
      clearImem();
      imem[0] = mk(c_ADDI, 1, 0, 8'd5);
      imem[1] = mk(c_ADDI, 2, 0, 8'd3);
      imem[2] = mk(c_ADD, 3, 1, 8'h20);
      imem[3] = mk(c_STORE, 3, 0, 8'd16);
      imem[4] = mk(c_LOAD, 4, 0, 8'd16);
      imem[5] = mk(c_ADD, 5, 4, 8'h40);
      imem[6] = mk(c_STORE, 5, 0, 8'd17);
      doReset();
      runCycles(30);
      checkEq("chain_nstores", storeQ.size(), 2);
      checkEq("chain_st0", storeQ.size() > 0 ? storeQ[0] : 64'hDEAD, pk(16, 8));
      checkEq("chain_st1", storeQ.size() > 1 ? storeQ[1] : 64'hDEAD, pk(17, 16));
      checkEq("chain_stalls", stallCnt, c_EXP_STALL_LD);

      // Taken BEQ squashes PC 11,12; untaken BEQ is free
      clearImem();
      imem[0]  = mk(c_ADDI, 1, 0, 8'd5);
      imem[1]  = mk(c_ADDI, 2, 0, 8'd3);
      imem[10] = mk(c_BEQ, 1, 1, 8'd2);
      imem[11] = mk(c_ADDI, 8, 0, 8'd7);
      imem[12] = mk(c_STORE, 1, 0, 8'd40);
      imem[13] = mk(c_BEQ, 1, 2, 8'd5);
      imem[14] = mk(c_STORE, 8, 0, 8'd41);
      doReset();
      runCycles(30);
      checkEq("br_flushes", flushCnt, 1);
      checkEq("br_target", 64'(afterFlushPc), 13);
      checkEq("br_nstores", storeQ.size(), 1);
      checkEq("br_st0", storeQ.size() > 0 ? storeQ[0] : 64'hDEAD, pk(41, 0));
      checkEq("br_stalls", stallCnt, 0);

      // Sign extension and wrap
      clearImem();
      imem[0] = mk(c_ADDI, 6, 0, 8'hFF);
      imem[1] = mk(c_ADDI, 7, 6, 8'd1);
      imem[2] = mk(c_STORE, 6, 0, 8'd0);
      imem[3] = mk(c_STORE, 7, 0, 8'd1);
      doReset();
      runCycles(25);
      checkEq("sx_nstores", storeQ.size(), 2);
      checkEq("sx_st0", storeQ.size() > 0 ? storeQ[0] : 64'hDEAD, pk(0, 20'hFFFFF));
      checkEq("sx_st1", storeQ.size() > 1 ? storeQ[1] : 64'hDEAD, pk(1, 0));

      // Back-to-back dependency
      clearImem();
      imem[0] = mk(c_ADDI, 1, 0, 8'd5);
      imem[1] = mk(c_ADD, 2, 1, 8'h10);
      imem[2] = mk(c_STORE, 2, 0, 8'd4);
      doReset();
      runCycles(25);
      checkEq("dep_stalls", stallCnt, c_EXP_STALL_DEP);
      checkEq("dep_nstores", storeQ.size(), 1);
      checkEq("dep_st0", storeQ.size() > 0 ? storeQ[0] : 64'hDEAD, pk(4, 10));

      // Asynchronous reset while a STORE is in MEM
      clearImem();
      imem[0] = mk(c_ADDI, 1, 0, 8'd9);
      imem[1] = mk(c_STORE, 1, 0, 8'd5);
      doReset();
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge Clock);
         if (W === 1'b1) found = 1'b1;
      end
      checkEq("ar_store_seen", 64'(found), 1);
      checkEq("ar_pre_dout", 64'(Dout), found ? 64'd9 : 64'd0);
      #2 Reset = 1'b0;
      #1;
      checkEq("ar_w", 64'(W), 0);
      checkEq("ar_daddr", 64'(Daddress), 0);
      checkEq("ar_dout", 64'(Dout), 0);
      checkEq("ar_pc", 64'(InstrAddress), 0);
      imem[0] = mk(c_STORE, 1, 0, 8'd6);
      imem[1] = c_NOP;
      clearMon();
      @(negedge Clock);
      Reset = 1'b1;
      #1 checkEq("ar_restart_pc0", 64'(InstrAddress), 0);
      @(posedge Clock);
      #1 checkEq("ar_restart_pc1", 64'(InstrAddress), 1);
      runCycles(12);
      checkEq("ar_nstores", storeQ.size(), 1);
      checkEq("ar_reg_cleared", storeQ.size() > 0 ? storeQ[0] : 64'hDEAD, pk(6, 0));

      // Random programs against the interpreter
      for (int p = 0; p < 5; p++) begin
         int len;
         clearImem();
         for (int i = 0; i < 32; i++) imem[i] = randInstr();
         for (int i = 1; i < 16; i++) imem[31 + i] = mk(c_STORE, 4'(i), 0, 8'(100 + i));
         len = 47;
         for (int i = 0; i < 256; i++) dmem[i] = DATA_W'($urandom);
         runModel(len);
         doReset();
         runCycles(400);
         checkEq($sformatf("rnd%0d_nstores", p), storeQ.size(), expQ.size());
         for (int i = 0; i < expQ.size() && i < storeQ.size(); i++)
            checkEq($sformatf("rnd%0d_st%0d", p, i), storeQ[i], expQ[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipeline_processor_hz.md
Name: pipeline_processor_hz

Overview:
Parametrised successor of the 5-stage pipeline processor: IF, ID, EX, MEM, WB with pipeline registers between stages. Width and register count are generalised. Adds a hazard unit that the previous generation lacks:
- EX-stage operand forwarding
- load-use stall
- branch/jump resolution in EX with flush

Instruction memory and data memory are external, both combinational-read. This is the top-level core.

Parameters:
DATA_W, 20, datapath and register width
NREG_W, 4, register-address width; 2**NREG_W registers
INSTR_W, 20, instruction width; IMM_W = INSTR_W-4-2*NREG_W (default 8)
PC_W, 12, instruction-address width

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
InstrIn  in  INSTR_W  instruction at InstrAddress, valid same cycle
InstrAddress  out  PC_W  current PC
DataIn  in  DATA_W  data-memory read data at Daddress, valid same cycle
Daddress  out  DATA_W  data-memory address (MEM stage)
Dout  out  DATA_W  data-memory write data (MEM stage)
W  out  1  data-memory write enable (MEM stage STORE)
Stall  out  1  load-use/RAW stall active this cycle
Flush  out  1  taken branch/jump in EX this cycle

Behaviour:
- Clock/reset: one clock, Clock; Reset asynchronous, active-low.
- Instruction format, fields in order from MSB:
  - op[4], rd[NREG_W], rs1[NREG_W], rs2[NREG_W]
  - imm = low IMM_W bits, overlapping rs2; sign-extended to DATA_W.
- Opcodes:
  - 0000 ADD: rd=rs1+rs2
  - 0001 SUB: rd=rs1-rs2
  - 0010 AND
  - 0100 OR
  - 0011 NOT: rd=~rs1
  - 0101 ADDI: rd=rs1+imm
  - 1011 LOAD: rd=M[rs1+imm]
  - 1100 STORE: M[rs1+imm]=rd
  - 1101 BEQ: if rd==rs1 then PC=PC_of_branch+1+imm
  - 1110 JMP: PC=PC_of_jump+1+imm
  - all others: NOP
  - Internal bubble encoding: 1111.
- Arithmetic is modulo 2**DATA_W (wrap, no flags). PC arithmetic is modulo 2**PC_W. Daddress = rs1+imm, full DATA_W.
- Reset values:
  - PC=0.
  - All pipeline registers hold NOP.
  - All registers = 0.
  - InstrAddress=0, Daddress=0, Dout=0, W=0, Stall=0, Flush=0.
  - A NOP in MEM drives Daddress=0 and Dout=0.
- Reset mid-operation clears everything immediately. W falls without waiting for a clock edge.
- Latency: an instruction fetched at edge n writes its register at edge n+4.
- Register file is write-first: a WB write is visible to the ID read in the same cycle.
- Forwarding to EX operands (rs1, rs2, and rd for STORE/BEQ):
  - Priority: EX/MEM result, then MEM/WB result, then ID/EX latched value.
  - Only forward from instructions that write a register: ALU ops, ADDI, LOAD.
  - A LOAD in EX/MEM is never forwarded; that case is prevented by the stall.
- Load-use stall:
  - Trigger: ID/EX holds LOAD and the ID instruction reads its rd.
  - Response: Stall=1 for exactly one cycle. PC and IF/ID hold; ID/EX receives a bubble.
- Branch/jump, when BEQ is taken or JMP is in EX:
  - Flush=1 for one cycle.
  - PC <= target.
  - IF/ID and ID/EX <= bubble, so the 2-instruction penalty is squashed.
  - A not-taken BEQ costs nothing.
- Flush and Stall in the same cycle: Flush wins. PC loads the target; IF/ID and ID/EX are bubbled.
- Only WB writes state; squashed instructions never write registers or memory.

Optional Feature:
FORWARD_EN
- Defined: forwarding and the load-use stall behave as above.
- Undefined: no forwarding paths. Stall=1 while any ID source register matches the rd of a register-writing instruction in EX or EX/MEM.
  - MEM/WB is excluded because write-first covers it.
  - A back-to-back dependency therefore stalls 2 cycles.

Test Plan:
- ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; STORE r3,[r0+16] back-to-back, FORWARD_EN -> Stall never 1; STORE in MEM drives W=1, Daddress=16, Dout=8.
- After the above: LOAD r4,[r0+16] (bench memory returns 8); ADD r5,r4,r4; STORE r5,[r0+17] -> Stall=1 exactly one cycle; W=1, Daddress=17, Dout=16.
- BEQ r1,r1,+2 at PC=10 (r1=5) -> Flush=1 one cycle; next InstrAddress=13; instructions at PC 11,12 produce no register/memory effect. BEQ r1,r2 (5!=3) -> Flush=0, sequential PC.
- ADDI r6,r0,-1 (imm=0xFF); ADDI r7,r6,1; STORE r6,[r0+0]; STORE r7,[r0+1] -> Dout=0xFFFFF then 0x00000 (sign-extend and wrap).
- Reset pulled low mid-cycle while a STORE is in MEM -> W, Daddress, Dout, InstrAddress go to 0 before the next edge; after release, fetch restarts at PC 0 with registers 0.
- FORWARD_EN undefined, ADDI r1,r0,5; ADD r2,r1,r1; STORE r2,[r0+4] -> Stall=1 for 2 cycles before ADD enters EX; Dout=10 at the STORE.
